// File: rtl/shift_add_multiplier_pipelined.sv
// Pipelined shift-add multiplier (signed/unsigned) with valid/ready flow control and a tag sideband.
// Optional feature macro SHIFT_ADD_MULT_ACCUMULATE_EN adds i_addend, summed into the product.
module shift_add_multiplier_pipelined #(
  parameter int OPERAND_WIDTH  = 8,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_signed,
  input  logic [OPERAND_WIDTH-1:0]     i_operand_a,
  input  logic [OPERAND_WIDTH-1:0]     i_operand_b,
`ifdef SHIFT_ADD_MULT_ACCUMULATE_EN
  input  logic [2*OPERAND_WIDTH-1:0]   i_addend,
`endif
  input  logic [TAG_WIDTH-1:0]         i_tag,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [2*OPERAND_WIDTH-1:0]   o_result,
  output logic [TAG_WIDTH-1:0]         o_tag
);

  localparam int OW         = OPERAND_WIDTH;
  localparam int BPS        = BITS_PER_STAGE;
  localparam int RW         = 2 * OPERAND_WIDTH;
  localparam int NUM_STAGES = OPERAND_WIDTH / BITS_PER_STAGE;

  if (BPS < 1 || (OW % BPS) != 0) begin : g_bad_cfg
    $error("BITS_PER_STAGE must divide OPERAND_WIDTH");
  end

  logic [NUM_STAGES:0]   rdy;
  logic [NUM_STAGES-1:0] vld;
  logic                  init_q;

  // Holds o_ready low until the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) init_q <= 1'b0;
    else            init_q <= 1'b1;
  end

  always_comb begin
    rdy             = '0;
    rdy[NUM_STAGES] = i_ready;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      rdy[NUM_STAGES-1-i] = ~vld[NUM_STAGES-1-i] | rdy[NUM_STAGES-i];
    end
  end

  assign o_ready = rdy[0] & init_q;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : stage
    localparam int REM_IN  = OW - k * BPS;
    localparam int REM_OUT = REM_IN - BPS;

    logic              v_in;
    logic              s_in;
    logic [OW-1:0]     a_in;
    logic [REM_IN-1:0] b_in;
    logic [RW-1:0]     p_in;
    logic [TAG_WIDTH-1:0] t_in;
    logic [RW-1:0]     ext;
    logic [RW-1:0]     p_next;

    logic              v_q;
    logic [RW-1:0]     p_q;
    logic [TAG_WIDTH-1:0] t_q;

    if (k == 0) begin : g_src
      assign v_in = i_valid & init_q;
      assign s_in = i_signed;
      assign a_in = i_operand_a;
      assign b_in = i_operand_b;
      assign t_in = i_tag;
`ifdef SHIFT_ADD_MULT_ACCUMULATE_EN
      assign p_in = i_addend;
`else
      assign p_in = '0;
`endif
    end else begin : g_src
      assign v_in = stage[k-1].v_q;
      assign s_in = stage[k-1].g_keep.s_q;
      assign a_in = stage[k-1].g_keep.a_q;
      assign b_in = stage[k-1].g_keep.b_q;
      assign t_in = stage[k-1].t_q;
      assign p_in = stage[k-1].p_q;
    end

    // The weight-2^(OW-1) bit of B is negative in two's complement, so it is subtracted.
    always_comb begin
      ext    = s_in ? {{OW{a_in[OW-1]}}, a_in} : {{OW{1'b0}}, a_in};
      p_next = p_in;
      for (int unsigned j = 0; j < BPS; j++) begin
        if (b_in[j]) begin
          if (s_in && (k * BPS + j == OW - 1)) p_next = p_next - (ext << (k * BPS + j));
          else                                 p_next = p_next + (ext << (k * BPS + j));
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        v_q <= 1'b0;
        p_q <= '0;
        t_q <= '0;
      end else if (rdy[k]) begin
        v_q <= v_in;
        p_q <= p_next;
        t_q <= t_in;
      end
    end

    // Only stages that feed a later stage keep A, the sign flag and the unconsumed B bits.
    if (REM_OUT > 0) begin : g_keep
      logic               s_q;
      logic [OW-1:0]      a_q;
      logic [REM_OUT-1:0] b_q;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          s_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k]) begin
          s_q <= s_in;
          a_q <= a_in;
          b_q <= b_in[REM_IN-1:BPS];
        end
      end
    end

    assign vld[k] = v_q;
  end

  assign o_valid  = vld[NUM_STAGES-1];
  assign o_result = stage[NUM_STAGES-1].p_q;
  assign o_tag    = stage[NUM_STAGES-1].t_q;

endmodule

// File: tb/tb_shift_add_multiplier_pipelined.sv
// Self-checking bench for shift_add_multiplier_pipelined (OW=8, BPS=2, latency 4) with a result scoreboard.
module tb_shift_add_multiplier_pipelined;
  localparam int OW  = 8;
  localparam int BPS = 2;
  localparam int TW  = 4;
  localparam int RW  = 2 * OW;
  localparam int LAT = OW / BPS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic          sgn = 1'b0;
  logic [OW-1:0] op_a = '0;
  logic [OW-1:0] op_b = '0;
  logic [RW-1:0] addend = '0;
  logic [TW-1:0] tag = '0;
  logic          r_valid;
  logic          r_ready = 1'b1;
  logic [RW-1:0] result;
  logic [TW-1:0] r_tag;

  int tests = 0;
  int fails = 0;
  logic [RW+TW-1:0] sb[$];

  always #5 clk = ~clk;

  shift_add_multiplier_pipelined #(
    .OPERAND_WIDTH (OW),
    .BITS_PER_STAGE(BPS),
    .TAG_WIDTH     (TW)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_valid    (a_valid),
    .o_ready    (a_ready),
    .i_signed   (sgn),
    .i_operand_a(op_a),
    .i_operand_b(op_b),
`ifdef SHIFT_ADD_MULT_ACCUMULATE_EN
    .i_addend   (addend),
`endif
    .i_tag      (tag),
    .o_valid    (r_valid),
    .i_ready    (r_ready),
    .o_result   (result),
    .o_tag      (r_tag)
  );

  function automatic logic [RW-1:0] model(input logic s, input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic [RW-1:0] add);
    logic signed [RW-1:0] xa, xb;
    logic [RW-1:0] p;
    if (s) begin
      xa = $signed(a);
      xb = $signed(b);
      p  = xa * xb;
    end else begin
      p = {{OW{1'b0}}, a} * {{OW{1'b0}}, b};
    end
`ifdef SHIFT_ADD_MULT_ACCUMULATE_EN
    return p + add;
`else
    if (add != '0) p = p;
    return p;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (r_valid !== 1'b0 || result !== '0 || r_tag !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%h, required 0/0000/0", r_valid, result, r_tag);
    end
    tests++;
    if (a_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 0", a_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    tests++;
    if (a_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_at_release: got %b, required 0", a_ready);
    end
    tick();
    tests++;
    if (a_ready !== 1'b1 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_release: got ready=%b valid=%b, required 1/0", a_ready, r_valid);
    end
  endtask

  task automatic test_unsigned_max();
    int n;
    r_ready = 1'b1;
    a_valid = 1'b1; sgn = 1'b0; op_a = 8'hFF; op_b = 8'hFF; tag = 4'h5;
    @(negedge clk);
    tests++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL max_accept: got ready=%b, required 1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    n = 1;
    while (r_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n != LAT) begin
      fails++;
      $display("FAIL max_latency: got %0d cycles, required %0d", n, LAT);
    end
    tests++;
    if (result !== 16'hFE01 || r_tag !== 4'h5) begin
      fails++;
      $display("FAIL max_result: got %h tag %h, required fe01 tag 5", result, r_tag);
    end
    tick();
  endtask

  task automatic test_signed_mixed();
    logic [OW-1:0] av[3] = '{8'h80, 8'h7F, 8'h80};
    logic [OW-1:0] bv[3] = '{8'hFF, 8'h80, 8'hFF};
    logic          sv[3] = '{1'b1, 1'b1, 1'b0};
    logic [RW-1:0] rv[3] = '{16'h0080, 16'hC080, 16'h7F80};
    logic [RW+TW-1:0] want;
    int got = 0;
    r_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; sgn = sv[i]; op_a = av[i]; op_b = bv[i]; tag = 4'(i + 8);
      @(negedge clk);
      tests++;
      if (a_ready !== 1'b1) begin
        fails++;
        $display("FAIL mixed_accept%0d: got ready=%b, required 1", i, a_ready);
      end else sb.push_back({4'(i + 8), rv[i]});
      tick();
    end
    a_valid = 1'b0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (r_valid) begin
        got++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL mixed_extra: got %h tag %h, required no output", result, r_tag);
        end else begin
          want = sb.pop_front();
          if ({r_tag, result} !== want) begin
            fails++;
            $display("FAIL mixed_result: got %h tag %h, required %h tag %h", result, r_tag, want[RW-1:0], want[RW+TW-1:RW]);
          end
        end
      end
      tick();
    end
    tests++;
    if (got != 3) begin
      fails++;
      $display("FAIL mixed_count: got %0d results, required 3", got);
    end
  endtask

  task automatic test_stall();
    int issued = 0, got = 0;
    logic held = 1'b0;
    logic [RW-1:0] prev_res = '0;
    logic [TW-1:0] prev_tag = '0;
    logic [RW+TW-1:0] want;
    logic exp_rdy;
    for (int c = 0; c < 60 && got < 10; c++) begin
      a_valid = (issued < 10);
      sgn = c[0]; op_a = 8'($urandom); op_b = 8'($urandom); tag = 4'(issued);
      r_ready = !(c >= 5 && c < 11);
      @(negedge clk);
      exp_rdy = (sb.size() < LAT) || r_ready;
      tests++;
      if (a_ready !== exp_rdy) begin
        fails++;
        $display("FAIL stall_ready c%0d: got %b, required %b", c, a_ready, exp_rdy);
      end
      if (held) begin
        tests++;
        if (r_valid !== 1'b1 || result !== prev_res || r_tag !== prev_tag) begin
          fails++;
          $display("FAIL stall_hold c%0d: got %b/%h/%h, required 1/%h/%h", c, r_valid, result, r_tag, prev_res, prev_tag);
        end
      end
      held = r_valid && !r_ready;
      prev_res = result; prev_tag = r_tag;
      if (r_valid && r_ready) begin
        got++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL stall_extra: got %h tag %h, required no output", result, r_tag);
        end else begin
          want = sb.pop_front();
          if ({r_tag, result} !== want) begin
            fails++;
            $display("FAIL stall_result: got %h tag %h, required %h tag %h", result, r_tag, want[RW-1:0], want[RW+TW-1:RW]);
          end
        end
      end
      if (a_valid && a_ready) begin
        sb.push_back({tag, model(sgn, op_a, op_b, addend)});
        issued++;
      end
      tick();
    end
    a_valid = 1'b0; r_ready = 1'b1;
    tests++;
    if (got != 10 || sb.size() != 0) begin
      fails++;
      $display("FAIL stall_count: got %0d results with %0d pending, required 10 with 0", got, sb.size());
    end
  endtask

  task automatic test_reset_inflight();
    int issued = 0, got = 0;
    logic [RW+TW-1:0] want;
    r_ready = 1'b1;
    while (issued < 3) begin
      a_valid = 1'b1; sgn = 1'b0; op_a = 8'(issued + 3); op_b = 8'h11; tag = 4'(issued);
      @(negedge clk);
      if (a_ready) issued++;
      tick();
    end
    a_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (r_valid !== 1'b0 || result !== '0 || r_tag !== '0) begin
      fails++;
      $display("FAIL inflight_reset: got valid=%b result=%h tag=%h, required 0/0000/0", r_valid, result, r_tag);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    a_valid = 1'b1; sgn = 1'b1; op_a = 8'hFD; op_b = 8'h07; tag = 4'hA;
    @(negedge clk);
    tests++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_accept: got %b, required 1", a_ready);
    end else sb.push_back({4'hA, 16'hFFEB});
    tick();
    a_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (r_valid) begin
        got++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL post_reset_stale: got %h tag %h, required no output", result, r_tag);
        end else begin
          want = sb.pop_front();
          if ({r_tag, result} !== want) begin
            fails++;
            $display("FAIL post_reset_result: got %h tag %h, required %h tag %h", result, r_tag, want[RW-1:0], want[RW+TW-1:RW]);
          end
        end
      end
      tick();
    end
    tests++;
    if (got != 1) begin
      fails++;
      $display("FAIL post_reset_count: got %0d results, required 1", got);
    end
  endtask

  task automatic test_random();
    int issued = 0, got = 0, c = 0;
    logic [RW+TW-1:0] want;
    logic exp_rdy;
    while ((issued < 3000 || sb.size() != 0) && c < 30000) begin
      a_valid = (issued < 3000) && ($urandom_range(0, 9) < 7);
      r_ready = (issued >= 3000) || ($urandom_range(0, 9) < 7);
      sgn = 1'($urandom);
      op_a = ($urandom_range(0, 7) == 0) ? {1'b1, 7'($urandom_range(0, 1) * 7'h7F)} : 8'($urandom);
      op_b = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      tag = 4'($urandom);
      @(negedge clk);
      exp_rdy = (sb.size() < LAT) || r_ready;
      tests++;
      if (a_ready !== exp_rdy) begin
        fails++;
        $display("FAIL random_ready c%0d: got %b, required %b", c, a_ready, exp_rdy);
      end
      if (r_valid && r_ready) begin
        got++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL random_extra: got %h tag %h, required no output", result, r_tag);
        end else begin
          want = sb.pop_front();
          if ({r_tag, result} !== want) begin
            fails++;
            $display("FAIL random_result: got %h tag %h, required %h tag %h", result, r_tag, want[RW-1:0], want[RW+TW-1:RW]);
          end
        end
      end
      if (a_valid && a_ready) begin
        sb.push_back({tag, model(sgn, op_a, op_b, addend)});
        issued++;
      end
      tick();
      c++;
    end
    a_valid = 1'b0; r_ready = 1'b1;
    tests++;
    if (got != 3000 || sb.size() != 0) begin
      fails++;
      $display("FAIL random_count: got %0d results with %0d pending, required 3000 with 0", got, sb.size());
    end
  endtask

`ifdef SHIFT_ADD_MULT_ACCUMULATE_EN
  task automatic test_accumulate();
    int n = 0;
    r_ready = 1'b1;
    a_valid = 1'b1; sgn = 1'b0; op_a = 8'h10; op_b = 8'h10; addend = 16'hFFFF; tag = 4'h3;
    @(negedge clk);
    tick();
    a_valid = 1'b0; addend = '0;
    while (r_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (result !== 16'h00FF || r_tag !== 4'h3) begin
      fails++;
      $display("FAIL accumulate_wrap: got %h tag %h, required 00ff tag 3", result, r_tag);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_mixed();
    test_stall();
    test_reset_inflight();
`ifdef SHIFT_ADD_MULT_ACCUMULATE_EN
    test_accumulate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
